// File: rtl/axi_ram_wr_fifo.sv
// Synchronous command FIFO for the RAM write port.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module axi_ram_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO refuses a push even when the head is popped in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/axi_ram_wr_port.sv
// Write-side RAM back end: queues write commands, commits them into a
// byte-enabled array, reports burst completion and offers a debug read port.
module axi_ram_wr_port #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int VALID_ADDR_WIDTH = ADDR_WIDTH - $clog2(STRB_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ID_WIDTH-1:0]         ram_wr_cmd_id,
  input  logic [ADDR_WIDTH-1:0]       ram_wr_cmd_addr,
  input  logic [DATA_WIDTH-1:0]       ram_wr_cmd_data,
  input  logic [STRB_WIDTH-1:0]       ram_wr_cmd_strb,
  input  logic                        ram_wr_cmd_en,
  input  logic                        ram_wr_cmd_last,
  output logic                        ram_wr_cmd_ready,
  input  logic                        ram_wr_stall,
  output logic                        wr_done_valid,
  output logic [ID_WIDTH-1:0]         wr_done_id,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  input  logic                        dbg_rd_en,
  input  logic [VALID_ADDR_WIDTH-1:0] dbg_rd_addr,
  output logic [DATA_WIDTH-1:0]       dbg_rd_data
);

  localparam int LSB     = $clog2(STRB_WIDTH);
  localparam int ENTRY_W = ID_WIDTH + VALID_ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH + 1;

  logic [DATA_WIDTH-1:0]       ram_q [2**VALID_ADDR_WIDTH];
  logic [ENTRY_W-1:0]          push_entry, head_entry;
  logic                        fifo_full, fifo_empty, pop;
  logic [ID_WIDTH-1:0]         head_id;
  logic [VALID_ADDR_WIDTH-1:0] head_word;
  logic [DATA_WIDTH-1:0]       head_data;
  logic [STRB_WIDTH-1:0]       head_strb;
  logic                        head_last;
  logic                        wr_done_valid_q;
  logic [ID_WIDTH-1:0]         wr_done_id_q;
  logic [DATA_WIDTH-1:0]       dbg_rd_data_q;
  logic                        unused_addr_bits;

  assign unused_addr_bits = ^ram_wr_cmd_addr[LSB-1:0];

  assign push_entry = {ram_wr_cmd_id, ram_wr_cmd_addr[ADDR_WIDTH-1:LSB],
                       ram_wr_cmd_data, ram_wr_cmd_strb, ram_wr_cmd_last};
  assign {head_id, head_word, head_data, head_strb, head_last} = head_entry;

  assign ram_wr_cmd_ready = !rst && !fifo_full;
  assign pop              = !fifo_empty && !ram_wr_stall;

  axi_ram_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ram_wr_cmd_en && ram_wr_cmd_ready),
    .data_i  (push_entry),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .data_o  (head_entry),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Array is deliberately not reset so committed data survives a reset pulse.
  always_ff @(posedge clk) begin
    if (pop) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (head_strb[i]) ram_q[head_word][8*i +: 8] <= head_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_done_valid_q <= 1'b0;
      wr_done_id_q    <= '0;
      dbg_rd_data_q   <= '0;
    end else begin
      wr_done_valid_q <= pop && head_last;
      if (pop && head_last) wr_done_id_q <= head_id;
      if (dbg_rd_en) dbg_rd_data_q <= ram_q[dbg_rd_addr];
    end
  end

  assign wr_done_valid = wr_done_valid_q;
  assign wr_done_id    = wr_done_id_q;
  assign dbg_rd_data   = dbg_rd_data_q;

endmodule

// File: tb/tb_axi_ram_wr_port.sv
// Scoreboard bench for axi_ram_wr_port: directed writes push expected
// completions and read data into queues; a monitor pops and compares.
module tb_axi_ram_wr_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ram_wr_cmd_id = '0;
  logic [11:0] ram_wr_cmd_addr = '0;
  logic [31:0] ram_wr_cmd_data = '0;
  logic [3:0]  ram_wr_cmd_strb = '0;
  logic        ram_wr_cmd_en = 1'b0;
  logic        ram_wr_cmd_last = 1'b0;
  logic        ram_wr_cmd_ready;
  logic        ram_wr_stall = 1'b0;
  logic        wr_done_valid;
  logic [7:0]  wr_done_id;
  logic [2:0]  fifo_count;
  logic        dbg_rd_en = 1'b0;
  logic [9:0]  dbg_rd_addr = '0;
  logic [31:0] dbg_rd_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic rd_fire = 1'b0;

  typedef struct {
    logic [7:0] id;
    int         cyc;
  } done_t;

  done_t       exp_done [$];
  logic [31:0] exp_rd [$];

  axi_ram_wr_port dut (
    .clk              (clk),
    .rst              (rst),
    .ram_wr_cmd_id    (ram_wr_cmd_id),
    .ram_wr_cmd_addr  (ram_wr_cmd_addr),
    .ram_wr_cmd_data  (ram_wr_cmd_data),
    .ram_wr_cmd_strb  (ram_wr_cmd_strb),
    .ram_wr_cmd_en    (ram_wr_cmd_en),
    .ram_wr_cmd_last  (ram_wr_cmd_last),
    .ram_wr_cmd_ready (ram_wr_cmd_ready),
    .ram_wr_stall     (ram_wr_stall),
    .wr_done_valid    (wr_done_valid),
    .wr_done_id       (wr_done_id),
    .fifo_count       (fifo_count),
    .dbg_rd_en        (dbg_rd_en),
    .dbg_rd_addr      (dbg_rd_addr),
    .dbg_rd_data      (dbg_rd_data)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_fire <= dbg_rd_en && !rst;
  end

  // Monitor: compare every DUT response against the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_fire) begin
        if (exp_rd.size() == 0) chk("dbg_unexpected_read", 1, 0);
        else chk("dbg_rd_data", dbg_rd_data, exp_rd.pop_front());
      end
      if (wr_done_valid) begin
        if (exp_done.size() == 0) chk("wr_done_unexpected", {56'd0, wr_done_id}, 64'hFFFF);
        else begin
          done_t e;
          e = exp_done.pop_front();
          chk("wr_done_id", wr_done_id, e.id);
          if (e.cyc >= 0) chk("wr_done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // mode: 0 = no completion expected, 1 = completion untimed, 2 = completion timed
  task automatic send(input logic [7:0] id, input logic [11:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic last, input int mode);
    int n = 0;
    @(negedge clk);
    ram_wr_cmd_id   = id;
    ram_wr_cmd_addr = addr;
    ram_wr_cmd_data = data;
    ram_wr_cmd_strb = strb;
    ram_wr_cmd_last = last;
    ram_wr_cmd_en   = 1'b1;
    while (!ram_wr_cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ram_wr_cmd_ready) begin
      chk("send_timeout", 0, 1);
      ram_wr_cmd_en = 1'b0;
      return;
    end
    if (last && mode != 0) exp_done.push_back('{id, (mode == 2) ? cyc + 2 : -1});
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    ram_wr_cmd_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] e);
    @(negedge clk);
    dbg_rd_en   = 1'b1;
    dbg_rd_addr = a;
    exp_rd.push_back(e);
    @(negedge clk);
    dbg_rd_en = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (fifo_count != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_count", {61'd0, fifo_count}, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_ready", ram_wr_cmd_ready, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_done_valid", wr_done_valid, 0);
    chk("rst_done_id", wr_done_id, 0);
    chk("rst_dbg_data", dbg_rd_data, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", ram_wr_cmd_ready, 1);

    // Single beat
    send(8'h05, 12'h010, 32'hDEADBEEF, 4'hF, 1'b1, 2);
    idle();
    wait_empty();
    rd(10'h004, 32'hDEADBEEF);

    // Byte strobes
    send(8'h06, 12'h020, 32'h11223344, 4'hF, 1'b1, 2);
    idle();
    wait_empty();
    send(8'h07, 12'h020, 32'hAABBCCDD, 4'h5, 1'b1, 2);
    idle();
    wait_empty();
    rd(10'h008, 32'h11BB33DD);

    // Burst of four, one completion the cycle after the fourth commit
    for (int i = 0; i < 4; i++)
      send(8'h22, 12'h100 + 12'(4 * i), 32'(i + 1), 4'hF, (i == 3), 2);
    idle();
    wait_empty();
    for (int i = 0; i < 4; i++) rd(10'h040 + 10'(i), 32'(i + 1));

    // Stall: four accepted, ready drops, then drain in order
    ram_wr_stall = 1'b1;
    for (int i = 0; i < 4; i++)
      send(8'h10 + 8'(i), 12'h200 + 12'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b1, 1);
    @(negedge clk);
    chk("stall_count_full", fifo_count, 4);
    chk("stall_ready_low", ram_wr_cmd_ready, 0);
    fork
      begin
        send(8'h14, 12'h210, 32'hA4, 4'hF, 1'b1, 1);
        send(8'h15, 12'h214, 32'hA5, 4'hF, 1'b1, 1);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_still_full", fifo_count, 4);
        ram_wr_stall = 1'b0;
      end
    join
    wait_empty();
    for (int i = 0; i < 6; i++) rd(10'h080 + 10'(i), 32'hA0 + 32'(i));

    // Reset mid-operation discards queued entries
    for (int i = 0; i < 3; i++)
      send(8'h30 + 8'(i), 12'h0C0 + 12'(4 * i), 32'hC0 + 32'(i), 4'hF, 1'b1, 1);
    idle();
    wait_empty();
    ram_wr_stall = 1'b1;
    for (int i = 0; i < 3; i++)
      send(8'h40 + 8'(i), 12'h0C0 + 12'(4 * i), 32'hE0 + 32'(i), 4'hF, 1'b1, 0);
    @(negedge clk);
    ram_wr_cmd_en = 1'b0;
    chk("pre_rst_count", fifo_count, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_ready", ram_wr_cmd_ready, 0);
    rst = 1'b0;
    ram_wr_stall = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_count", fifo_count, 0);
    for (int i = 0; i < 3; i++) rd(10'h030 + 10'(i), 32'hC0 + 32'(i));
    rd(10'h004, 32'hDEADBEEF);

    // Read/commit collision returns old data first
    send(8'h50, 12'h080, 32'h12345678, 4'hF, 1'b1, 2);
    idle();
    wait_empty();
    send(8'h51, 12'h080, 32'h00000055, 4'hF, 1'b1, 2);
    @(negedge clk);
    ram_wr_cmd_en = 1'b0;
    dbg_rd_en     = 1'b1;
    dbg_rd_addr   = 10'h020;
    exp_rd.push_back(32'h12345678);
    @(negedge clk);
    exp_rd.push_back(32'h00000055);
    @(negedge clk);
    dbg_rd_en = 1'b0;
    repeat (4) @(negedge clk);

    chk("leftover_done", exp_done.size(), 0);
    chk("leftover_rd", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
